// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - packet round-robin arbiter feeding a UART TX byte stream
module uart_tx_arb #(
  parameter int N      = 4,
  parameter int ID_W   = $clog2(N),
  parameter int HDR_EN = 1,
  parameter int TO_W   = 16
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            En,
  input  logic [TO_W-1:0] timeout,
  input  logic [N*8-1:0]  s_tdata,
  input  logic [N-1:0]    s_tvalid,
  input  logic [N-1:0]    s_tlast,
  output logic [N-1:0]    s_tready,
  output logic [7:0]      m_tdata,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            to_err
);

  // The header carries the source ID in its low nibble, so more than 16 sources cannot be encoded.
  generate
    if (N < 2 || N > 16) begin : g_bad_n
      $error("uart_tx_arb: N must be in 2..16");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PASS} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic            grant_valid_q, grant_valid_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            to_err_q, to_err_d;

  logic            sel_found;
  logic [ID_W-1:0] sel_idx;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;
  logic [ID_W-1:0] next_ptr;

  // First requester at or after the rotating pointer, wrapping modulo N.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!sel_found && s_tvalid[(int'(ptr_q) + k) % N]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'((int'(ptr_q) + k) % N);
      end
    end
  end

  assign g_valid  = s_tvalid[grant_id_q];
  assign g_last   = s_tlast[grant_id_q];
  assign g_data   = s_tdata[{grant_id_q, 3'b000} +: 8];
  assign next_ptr = (grant_id_q == ID_W'(N - 1)) ? '0 : grant_id_q + ID_W'(1);

  // Next-state, stall counter and datapath steering; outputs are forced idle while in reset.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    cnt_d         = cnt_q;
    to_err_d      = 1'b0;
    m_tdata       = 8'h00;
    m_tvalid      = 1'b0;
    s_tready      = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (En && sel_found) begin
          grant_id_d    = sel_idx;
          grant_valid_d = 1'b1;
          state_d       = (HDR_EN != 0) ? ST_HDR : ST_PASS;
        end
      end
      ST_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = 8'hA0 | 8'(grant_id_q);
        cnt_d    = '0;
        if (m_tready) begin
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        m_tdata              = g_data;
        m_tvalid             = g_valid;
        s_tready[grant_id_q] = m_tready;
        if (g_valid && m_tready) begin
          cnt_d = '0;
          if (g_last) begin
            state_d       = ST_IDLE;
            ptr_d         = next_ptr;
            grant_valid_d = 1'b0;
          end
        end else if (!g_valid) begin
          // Only a silent source counts as a stall; sink backpressure does not.
          if (timeout != '0 && cnt_q == timeout - TO_W'(1)) begin
            state_d       = ST_IDLE;
            ptr_d         = next_ptr;
            grant_valid_d = 1'b0;
            to_err_d      = 1'b1;
            cnt_d         = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (Rst) begin
      m_tvalid = 1'b0;
      s_tready = '0;
    end
  end

  // State register with synchronous reset; a reset mid-packet simply drops the grant.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      cnt_q         <= '0;
      to_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      cnt_q         <= cnt_d;
      to_err_q      <= to_err_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != ST_IDLE);
  assign to_err      = to_err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - randomized and directed checks of uart_tx_arb against a packet-level model
module tb_uart_tx_arb;

  logic        Clk = 1'b0;
  logic        Rst, En;
  logic [15:0] timeout;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid, s_tlast, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, grant_valid, busy, to_err;
  logic [1:0]  grant_id;

  logic        b_Rst, b_En;
  logic [15:0] b_timeout;
  logic [31:0] b_s_tdata;
  logic [3:0]  b_s_tvalid, b_s_tlast, b_s_tready;
  logic [7:0]  b_m_tdata;
  logic        b_m_tvalid, b_m_tready, b_grant_valid, b_busy, b_to_err;
  logic [1:0]  b_grant_id;

  always #5 Clk = ~Clk;

  uart_tx_arb #(.N(4), .HDR_EN(1), .TO_W(16)) u_dut (
    .Clk(Clk), .Rst(Rst), .En(En), .timeout(timeout),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .grant_valid(grant_valid), .grant_id(grant_id), .busy(busy), .to_err(to_err)
  );

  uart_tx_arb #(.N(4), .HDR_EN(0), .TO_W(16)) u_dut_nohdr (
    .Clk(Clk), .Rst(b_Rst), .En(b_En), .timeout(b_timeout),
    .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tlast(b_s_tlast), .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
    .grant_valid(b_grant_valid), .grant_id(b_grant_id), .busy(b_busy), .to_err(b_to_err)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_d [4][32];
  bit         mem_l [4][32];
  int         wr [4];
  int         rd [4];
  int         stall_at [4];
  bit         held [4];
  bit         mid [4];
  bit         gap_en, rdy_rand, gap_chk;
  bit         rdy_q [$];
  logic [7:0] obs_q [$];
  logic [7:0] exp_q [$];
  int         done_src_q [$];
  int         exp_src_q [$];
  int         cyc, hs_cyc, to_err_cnt, to_err_gap;
  logic       to_err_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_byte(input int src, input logic [7:0] d, input bit last);
    mem_d[src][wr[src]] = d;
    mem_l[src][wr[src]] = last;
    wr[src]++;
  endtask

  task automatic add_pkt(input int src, input int len);
    for (int b = 0; b < len; b++) add_byte(src, 8'($urandom), (b == len - 1));
  endtask

  function automatic bit pending();
    for (int i = 0; i < 4; i++) if (rd[i] < wr[i] && rd[i] != stall_at[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: pure packet-level round robin over sources with queued packets, starting at source 0.
  task automatic build_exp();
    int  p;
    int  pos [4];
    bit  found;
    exp_q.delete();
    exp_src_q.delete();
    p = 0;
    pos = '{0, 0, 0, 0};
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (p + k) % 4;
        if (!found && pos[i] < wr[i]) begin
          found = 1'b1;
          exp_q.push_back(8'hA0 | 8'(i));
          do begin
            exp_q.push_back(mem_d[i][pos[i]]);
            pos[i]++;
          end while (!mem_l[i][pos[i] - 1]);
          exp_src_q.push_back(i);
          p = (i + 1) % 4;
        end
      end
    end
  endtask

  // Sources hold a presented byte until it is taken; optional gaps only inside a packet.
  task automatic apply_inputs();
    for (int i = 0; i < 4; i++) begin
      logic v;
      v = 1'b0;
      if (rd[i] < wr[i] && rd[i] != stall_at[i]) begin
        if (held[i]) v = 1'b1;
        else if (gap_en && mid[i] && $urandom_range(0, 2) == 0) v = 1'b0;
        else v = 1'b1;
      end
      held[i] = v;
      s_tvalid[i] = v;
      s_tlast[i] = v ? mem_l[i][rd[i]] : 1'b0;
      s_tdata[i*8 +: 8] = v ? mem_d[i][rd[i]] : 8'h00;
    end
    if (rdy_q.size() > 0) m_tready = rdy_q.pop_front();
    else if (rdy_rand) m_tready = 1'($urandom_range(0, 1));
    else m_tready = 1'b1;
  endtask

  task automatic step();
    bit pop [4];
    @(negedge Clk);
    if (m_tvalid && m_tready) begin
      obs_q.push_back(m_tdata);
      hs_cyc = cyc;
    end
    if (gap_chk) chk("idle_gap", busy, 0);
    gap_chk = 1'b0;
    chk("rdy_onehot", 32'($countones(s_tready) <= 1), 1);
    for (int i = 0; i < 4; i++) begin
      pop[i] = 1'b0;
      if (s_tvalid[i] && s_tready[i]) begin
        chk("grant_src", grant_id, i);
        pop[i] = 1'b1;
        if (s_tlast[i]) begin
          done_src_q.push_back(i);
          gap_chk = 1'b1;
        end
      end
    end
    if (to_err) begin
      to_err_cnt++;
      to_err_gap = cyc - hs_cyc;
      to_err_busy = busy;
    end
    cyc++;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) begin
        mid[i] = !mem_l[i][rd[i]];
        rd[i]++;
        held[i] = 1'b0;
      end
    end
    apply_inputs();
    #1;
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while ((pending() || busy) && n < budget) begin
      step();
      n++;
    end
    chk("cycle_budget", 32'(n < budget), 1);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) chk(tag, obs_q[k], exp_q[k]);
    chk({tag, "_npkt"}, done_src_q.size(), exp_src_q.size());
    for (int k = 0; k < exp_src_q.size() && k < done_src_q.size(); k++)
      chk({tag, "_src"}, done_src_q[k], exp_src_q[k]);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    En = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr[i] = 0; rd[i] = 0; stall_at[i] = -1; held[i] = 1'b0; mid[i] = 1'b0;
    end
    obs_q.delete(); done_src_q.delete(); rdy_q.delete();
    to_err_cnt = 0; to_err_gap = -1; to_err_busy = 1'bx;
    gap_en = 1'b0; rdy_rand = 1'b0; gap_chk = 1'b0;
    cyc = 0; hs_cyc = 0;
    apply_inputs();
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    apply_inputs();
    #1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    timeout = 16'd0;
    b_Rst = 1'b1; b_En = 1'b0; b_timeout = 16'd0; b_m_tready = 1'b1;
    b_s_tdata = '0; b_s_tvalid = '0; b_s_tlast = '0;

    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_to_err", to_err, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);

    // Single packet from source 2 with header
    do_reset();
    add_byte(2, 8'h11, 1'b0);
    add_byte(2, 8'h22, 1'b1);
    build_exp();
    En = 1'b1;
    apply_inputs();
    #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_mvalid", m_tvalid, 0);
    step();
    chk("t1_hdr_valid", m_tvalid, 1);
    chk("t1_hdr_data", m_tdata, 8'hA2);
    chk("t1_hdr_gid", grant_id, 2);
    chk("t1_hdr_gvalid", grant_valid, 1);
    chk("t1_hdr_sready", s_tready, 0);
    step();
    chk("t1_b0_data", m_tdata, 8'h11);
    chk("t1_b0_sready", s_tready, 4'b0100);
    step();
    chk("t1_b1_data", m_tdata, 8'h22);
    chk("t1_b1_busy", busy, 1);
    step();
    chk("t1_end_busy", busy, 0);
    chk("t1_end_gvalid", grant_valid, 0);
    chk("t1_end_gid_hold", grant_id, 2);
    chk_stream("t1_stream");

    // Round robin with all four sources streaming 2-byte packets
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add_pkt(i, 2);
      add_pkt(i, 2);
    end
    build_exp();
    En = 1'b1;
    apply_inputs();
    #1;
    run_until_done(200);
    chk_stream("t2_rr");

    // Sink backpressure 1,0,0,1 must not count as a stall even with a short timeout
    do_reset();
    timeout = 16'd3;
    add_pkt(1, 4);
    for (int r = 0; r < 10; r++) begin
      rdy_q.push_back(1'b1); rdy_q.push_back(1'b0); rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    end
    build_exp();
    En = 1'b1;
    apply_inputs();
    #1;
    run_until_done(200);
    chk_stream("t3_bp");
    chk("t3_no_to_err", to_err_cnt, 0);
    timeout = 16'd0;

    // Timeout: source 1 goes silent after one byte; source 2 is waiting
    do_reset();
    timeout = 16'd5;
    add_byte(1, 8'hAA, 1'b0);
    add_byte(1, 8'hBB, 1'b1);
    stall_at[1] = 1;
    add_byte(2, 8'hCC, 1'b1);
    exp_q.delete();
    exp_q.push_back(8'hA1); exp_q.push_back(8'hAA); exp_q.push_back(8'hA2); exp_q.push_back(8'hCC);
    exp_src_q.delete();
    exp_src_q.push_back(2);
    En = 1'b1;
    apply_inputs();
    #1;
    run_until_done(100);
    chk_stream("t4_to");
    chk("t4_to_cnt", to_err_cnt, 1);
    // Handshake at edge E0, five silent cycles end at E5, registered pulse is visible in the cycle after E5.
    chk("t4_to_gap", to_err_gap, 6);
    chk("t4_to_idle", to_err_busy, 0);
    chk("t4_src1_left", rd[1], 1);
    timeout = 16'd0;

    // En dropped mid-packet: source 0 completes, source 3 waits until En returns
    do_reset();
    add_pkt(0, 3);
    add_byte(3, 8'h5C, 1'b1);
    build_exp();
    En = 1'b1;
    apply_inputs();
    #1;
    step();
    En = 1'b0;
    chk("t5_gid0", grant_id, 0);
    begin
      int n;
      n = 0;
      while (!(rd[0] == wr[0] && !busy) && n < 50) begin
        step();
        n++;
      end
      chk("t5_budget", 32'(n < 50), 1);
    end
    repeat (4) step();
    chk("t5_blocked_rd3", rd[3], 0);
    chk("t5_blocked_busy", busy, 0);
    chk("t5_blocked_gvalid", grant_valid, 0);
    En = 1'b1;
    #1;
    chk("t5_en_idle", busy, 0);
    step();
    chk("t5_lat_busy", busy, 1);
    chk("t5_lat_gid", grant_id, 3);
    chk("t5_lat_hdr", m_tdata, 8'hA3);
    run_until_done(100);
    chk_stream("t5_en");

    // Randomized packets, intra-packet gaps and random sink ready
    for (int round = 0; round < 4; round++) begin
      do_reset();
      gap_en = 1'b1;
      rdy_rand = 1'b1;
      for (int i = 0; i < 4; i++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) add_pkt(i, $urandom_range(1, 4));
      end
      build_exp();
      En = 1'b1;
      apply_inputs();
      #1;
      run_until_done(2000);
      chk_stream("rnd");
    end

    // Headerless instance: reset mid-packet drops the grant and the pointer
    b_s_tdata = 32'h44_33_22_11;
    b_s_tvalid = 4'b0001;
    b_s_tlast = 4'b0001;
    b_En = 1'b1;
    @(posedge Clk);
    #1;
    b_Rst = 1'b0;
    #1;
    chk("t6_idle", b_busy, 0);
    @(posedge Clk);
    #2;
    chk("t6_nohdr_data", b_m_tdata, 8'h11);
    chk("t6_nohdr_valid", b_m_tvalid, 1);
    chk("t6_nohdr_sready", b_s_tready, 4'b0001);
    @(posedge Clk);
    #1;
    b_s_tvalid = 4'b1111;
    b_s_tlast = 4'b0000;
    #1;
    chk("t6_gap_busy", b_busy, 0);
    @(posedge Clk);
    #2;
    chk("t6_src1_gid", b_grant_id, 1);
    chk("t6_src1_data", b_m_tdata, 8'h22);
    @(posedge Clk);
    #2;
    chk("t6_mid_busy", b_busy, 1);
    b_Rst = 1'b1;
    #1;
    chk("t6_inrst_mvalid", b_m_tvalid, 0);
    chk("t6_inrst_sready", b_s_tready, 0);
    @(posedge Clk);
    #2;
    chk("t6_rst_mvalid", b_m_tvalid, 0);
    chk("t6_rst_sready", b_s_tready, 0);
    chk("t6_rst_busy", b_busy, 0);
    chk("t6_rst_gvalid", b_grant_valid, 0);
    chk("t6_rst_gid", b_grant_id, 0);
    b_Rst = 1'b0;
    @(posedge Clk);
    #2;
    chk("t6_regrant_gid", b_grant_id, 0);
    chk("t6_regrant_data", b_m_tdata, 8'h11);
    chk("t6_regrant_gvalid", b_grant_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Packet-granular round-robin arbiter sharing the single UART transmit byte stream among N AXI4-Stream requesters.
- Sits in front of the UART TX sink and drives its s_axis byte channel.
- Optionally prefixes each packet with a source-ID header byte.
- Releases a stalled grant after a programmable idle timeout.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(N), width of grant_id.
- HDR_EN, 1, 1 = emit a header byte before each packet; 0 = pass payload only.
- TO_W, 16, width of the timeout counter and of the timeout input.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset; synchronous, active-high
- En  in  1  arbitration enable; gates new grants only
- timeout  in  TO_W  mid-packet stall limit in cycles; 0 disables the timeout
- s_tdata  in  N*8  requester bytes; requester i uses [8i+7:8i]
- s_tvalid  in  N  per-requester valid
- s_tlast  in  N  per-requester end of packet
- s_tready  out  N  per-requester ready
- m_tdata  out  8  byte to UART TX
- m_tvalid  out  1  valid to UART TX
- m_tready  in  1  ready from UART TX
- grant_valid  out  1  a requester currently holds the grant
- grant_id  out  ID_W  current or last granted requester
- busy  out  1  state is not IDLE
- to_err  out  1  single-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset values: state=IDLE, ptr=0, grant_id=0, grant_valid=0, cnt=0, to_err=0.
- Reset effect on datapath: m_tvalid=0 and s_tready=0 while in reset. Reset mid-packet abandons the packet without emitting any further byte.
- States: IDLE, HDR, PASS.
- IDLE:
  - m_tvalid=0; all s_tready=0.
  - If En=1 and any s_tvalid is high, select the first requesting index at or after ptr, wrapping modulo N.
  - Register that index into grant_id and set grant_valid=1.
  - Next state is HDR if HDR_EN=1, else PASS.
  - Arbitration latency is exactly 1 cycle: the first byte is presented the cycle after the request is seen.
- HDR:
  - m_tvalid=1; m_tdata = 8'hA0 | grant_id (zero-extended); all s_tready=0.
  - On m_tready=1, go to PASS.
- PASS (combinational datapath through the granted requester g):
  - m_tdata = s_tdata[g]; m_tvalid = s_tvalid[g]; s_tready[g] = m_tready.
  - s_tready of every other requester = 0.
  - On a handshake with s_tlast[g]=1: go to IDLE, set ptr = (g+1) mod N, grant_valid=0.
- Timeout counter cnt:
  - Active only in PASS.
  - Cleared on entry to PASS and on every handshake.
  - Increments on each PASS cycle with s_tvalid[g]=0, saturating at all-ones.
  - If timeout!=0 and cnt reaches timeout-1 on a cycle with s_tvalid[g]=0: go to IDLE, pulse to_err for 1 cycle, set ptr=(g+1) mod N, grant_valid=0.
  - m_tready low with s_tvalid high does not count as a stall; the counter does not increment.
- En:
  - En=0 blocks new grants in IDLE only.
  - A packet in HDR or PASS always completes, or is revoked by timeout.
- Simultaneous requests: the rotating pointer guarantees each continuously requesting source is granted within N packets.
- busy = (state != IDLE).
- grant_id holds its value after release until the next grant.
- A single-byte packet (tlast on the first byte) is legal: HDR (if enabled) plus 1 byte, then IDLE.
- Back-to-back: after tlast there is always one IDLE cycle before the next grant.
- No byte from a non-granted requester is ever accepted.
- Header and payload bytes are never reordered.
- N>16 is illegal because the header ID field is 4 bits; elaboration fails on N>16.

Test Plan:
- After reset, HDR_EN=1, m_tready=1: src2 sends packet {0x11,0x22(last)} -> m_tdata sequence 0xA2,0x11,0x22; grant_id=2; busy high for 3 cycles, then IDLE.
- Round-robin: all 4 sources stream continuously with 2-byte packets -> grant order 0,1,2,3,0; s_tready never high for two sources at once.
- Backpressure: m_tready toggles 1,0,0,1 during PASS -> no byte lost or duplicated; counter does not advance; to_err stays 0.
- Timeout=5: src1 sends one byte, then drops tvalid -> to_err pulses exactly 5 cycles after the last handshake; state returns to IDLE; next grant goes to src2 if it is requesting.
- En=0 mid-packet: src0 packet completes; src3 request pending -> no grant until En=1, then src3 is granted with 1-cycle latency.
- HDR_EN=0, Rst asserted mid-packet -> m_tvalid=0, s_tready=0 next cycle; ptr=0; grant_valid=0; next grant is src0 when all request.
